axi_wr_arbiter_2x1: RTL and testbench
=====================================

AXI_WR_ARBITER_2X1 -- requirements
Module: axi_wr_arbiter_2x1

Interface
REQ-001 SHALL have parameter FIRST_GRANT, default 0: master granted first after reset when both request.
REQ-002 SHALL have port ACLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port ARESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports M0_AWVALID, M1_AWVALID  input  1 each  master write-address requests.
REQ-005 SHALL have ports M0_AWREADY, M1_AWREADY  output  1 each  address accept to masters.
REQ-006 SHALL have ports M0_WVALID, M0_WLAST, M1_WVALID, M1_WLAST  input  1 each  master write-data strobes.
REQ-007 SHALL have ports M0_WREADY, M1_WREADY  output  1 each.
REQ-008 SHALL have ports M0_BVALID, M1_BVALID  output  1 each; M0_BREADY, M1_BREADY  input  1 each.
REQ-009 SHALL have ports S_AWVALID, S_WVALID, S_WLAST, S_BREADY  output  1 each  towards slave.
REQ-010 SHALL have ports S_AWREADY, S_WREADY, S_BVALID  input  1 each  from slave.
REQ-011 SHALL have port sel  output  1  registered select driving the AW/W payload 2:1 muxes (0 = M0, 1 = M1).
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR, DATA, RESP; one write transaction in flight at a time.
REQ-014 IDLE: if exactly one AWVALID is high, SHALL grant that master; if both, SHALL grant ~last_grant; on grant, sel <= granted index and state <= ADDR on the same edge.
REQ-015 Arbitration latency SHALL be one cycle: AWVALID first high at edge N -> S_AWVALID high after edge N+1.
REQ-016 In IDLE, all *READY and *VALID outputs SHALL be 0.
REQ-017 ADDR: S_AWVALID = granted Mx_AWVALID; granted Mx_AWREADY = S_AWREADY; on S_AWVALID & S_AWREADY, state <= DATA.
REQ-018 DATA: S_WVALID = granted Mx_WVALID; S_WLAST = granted Mx_WLAST; granted Mx_WREADY = S_WREADY; on S_WVALID & S_WREADY & S_WLAST, state <= RESP.
REQ-019 RESP: granted Mx_BVALID = S_BVALID; S_BREADY = granted Mx_BREADY; on S_BVALID & S_BREADY, last_grant <= sel and state <= IDLE.
REQ-020 Non-granted master SHALL see AWREADY, WREADY, BVALID = 0 in every state.
REQ-021 W beats SHALL NOT be accepted before the AW handshake: WREADY = 0 and S_WVALID = 0 in ADDR.
REQ-022 sel SHALL remain constant from grant until the B handshake completes, so the payload muxes stay stable for the whole burst.
REQ-023 Deassertion of granted AWVALID in ADDR (protocol violation) SHALL NOT abort; FSM stays in ADDR.
REQ-024 Requests arriving in ADDR/DATA/RESP SHALL be ignored until IDLE; minimum IDLE dwell between transactions is one cycle.
REQ-025 Single-beat bursts (WLAST on first beat) SHALL go DATA -> RESP after one handshake.
REQ-026 Only the edge-to-edge transitions listed above SHALL be permitted; S_* outputs are combinational in state, sel is registered.

Reset
REQ-027 ARESET high at a rising edge SHALL force state = IDLE, sel = FIRST_GRANT, last_grant = ~FIRST_GRANT, busy = 0, and all *READY/*VALID outputs to 0 from the next cycle.
REQ-028 Reset asserted mid-transaction (any state) SHALL abandon the transaction without emitting further handshakes.

Verification
REQ-029 Both AWVALID high in IDLE after reset, FIRST_GRANT=0 -> sel=0 after one edge; M0 completes a 4-beat burst; next grant goes to M1 (sel=1).
REQ-030 Only M1 requests, 1-beat burst, S_AWREADY/S_WREADY/S_BVALID tied high -> IDLE, ADDR, DATA, RESP, IDLE in 5 cycles; M0 sees all ready/valid = 0.
REQ-031 M1_WVALID high before the AW handshake, S_AWREADY low 3 cycles -> M1_WREADY = 0 and S_WVALID = 0 until the AW handshake.
REQ-032 S_BVALID high, granted BREADY low 2 cycles -> FSM holds RESP, sel stable; advances on the cycle BREADY rises.
REQ-033 ARESET pulsed in DATA after 2 of 4 beats -> next cycle IDLE, busy=0, sel=FIRST_GRANT, all outputs 0.
REQ-034 Both masters request continuously for 4 transactions -> grants alternate 0,1,0,1 with no back-to-back repeat.

Source files
------------

// File: rtl/axi_wr_arbiter_2x1.sv
// Two-master to one-slave AXI write-channel arbiter.
// One write transaction in flight at a time; a registered select steers the AW/W payload muxes.
module axi_wr_arbiter_2x1 #(
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic M0_AWVALID,
  input  logic M1_AWVALID,
  output logic M0_AWREADY,
  output logic M1_AWREADY,
  input  logic M0_WVALID,
  input  logic M0_WLAST,
  input  logic M1_WVALID,
  input  logic M1_WLAST,
  output logic M0_WREADY,
  output logic M1_WREADY,
  output logic M0_BVALID,
  output logic M1_BVALID,
  input  logic M0_BREADY,
  input  logic M1_BREADY,
  output logic S_AWVALID,
  output logic S_WVALID,
  output logic S_WLAST,
  output logic S_BREADY,
  input  logic S_AWREADY,
  input  logic S_WREADY,
  input  logic S_BVALID,
  output logic sel,
  output logic busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e state_q;
  logic   sel_q;
  logic   last_grant_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      sel_q        <= FIRST_GRANT;
      last_grant_q <= ~FIRST_GRANT;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (M0_AWVALID && M1_AWVALID) begin
            sel_q   <= ~last_grant_q;
            state_q <= StAddr;
          end else if (M0_AWVALID || M1_AWVALID) begin
            sel_q   <= M1_AWVALID;
            state_q <= StAddr;
          end
        end
        // A dropped AWVALID here is a master protocol error; keep waiting rather than abort.
        StAddr: if (S_AWVALID && S_AWREADY) state_q <= StData;
        StData: if (S_WVALID && S_WREADY && S_WLAST) state_q <= StResp;
        StResp: begin
          if (S_BVALID && S_BREADY) begin
            last_grant_q <= sel_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel  = sel_q;
  assign busy = (state_q != StIdle);

  // Handshakes are only routed in the phase that owns them; everything else stays low.
  always_comb begin
    M0_AWREADY = 1'b0;
    M1_AWREADY = 1'b0;
    M0_WREADY  = 1'b0;
    M1_WREADY  = 1'b0;
    M0_BVALID  = 1'b0;
    M1_BVALID  = 1'b0;
    S_AWVALID  = 1'b0;
    S_WVALID   = 1'b0;
    S_WLAST    = 1'b0;
    S_BREADY   = 1'b0;
    unique case (state_q)
      StAddr: begin
        S_AWVALID = sel_q ? M1_AWVALID : M0_AWVALID;
        if (sel_q) M1_AWREADY = S_AWREADY;
        else       M0_AWREADY = S_AWREADY;
      end
      StData: begin
        S_WVALID = sel_q ? M1_WVALID : M0_WVALID;
        S_WLAST  = sel_q ? M1_WLAST  : M0_WLAST;
        if (sel_q) M1_WREADY = S_WREADY;
        else       M0_WREADY = S_WREADY;
      end
      StResp: begin
        S_BREADY = sel_q ? M1_BREADY : M0_BREADY;
        if (sel_q) M1_BVALID = S_BVALID;
        else       M0_BVALID = S_BVALID;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_wr_arbiter_2x1.sv
// Directed bench for axi_wr_arbiter_2x1; outputs are packed into one word per comparison:
// {busy, sel, M0 {awready,wready,bvalid}, M1 {awready,wready,bvalid}, S {awvalid,wvalid,wlast,bready}}
module tb_axi_wr_arbiter_2x1;

  logic ACLK = 1'b0;
  logic ARESET;
  logic M0_AWVALID, M1_AWVALID, M0_AWREADY, M1_AWREADY;
  logic M0_WVALID, M0_WLAST, M1_WVALID, M1_WLAST, M0_WREADY, M1_WREADY;
  logic M0_BVALID, M1_BVALID, M0_BREADY, M1_BREADY;
  logic S_AWVALID, S_WVALID, S_WLAST, S_BREADY, S_AWREADY, S_WREADY, S_BVALID;
  logic sel, busy;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_wr_arbiter_2x1 #(.FIRST_GRANT(1'b0)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .M0_AWVALID(M0_AWVALID),
    .M1_AWVALID(M1_AWVALID),
    .M0_AWREADY(M0_AWREADY),
    .M1_AWREADY(M1_AWREADY),
    .M0_WVALID (M0_WVALID),
    .M0_WLAST  (M0_WLAST),
    .M1_WVALID (M1_WVALID),
    .M1_WLAST  (M1_WLAST),
    .M0_WREADY (M0_WREADY),
    .M1_WREADY (M1_WREADY),
    .M0_BVALID (M0_BVALID),
    .M1_BVALID (M1_BVALID),
    .M0_BREADY (M0_BREADY),
    .M1_BREADY (M1_BREADY),
    .S_AWVALID (S_AWVALID),
    .S_WVALID  (S_WVALID),
    .S_WLAST   (S_WLAST),
    .S_BREADY  (S_BREADY),
    .S_AWREADY (S_AWREADY),
    .S_WREADY  (S_WREADY),
    .S_BVALID  (S_BVALID),
    .sel       (sel),
    .busy      (busy)
  );

  logic [11:0] obs;
  assign obs = {busy, sel, M0_AWREADY, M0_WREADY, M0_BVALID, M1_AWREADY, M1_WREADY, M1_BVALID,
                S_AWVALID, S_WVALID, S_WLAST, S_BREADY};

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    M0_AWVALID = 0; M1_AWVALID = 0;
    M0_WVALID = 0; M0_WLAST = 0; M1_WVALID = 0; M1_WLAST = 0;
    M0_BREADY = 0; M1_BREADY = 0;
    S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0;
  endtask

  task automatic do_reset(input string tag);
    ARESET = 1;
    clear_inputs();
    tick();
    tick();
    ARESET = 0;
    #1 check_eq(tag, obs, 12'b0_0_000_000_0000);
  endtask

  task automatic set_w(input logic m, input logic v, input logic last);
    if (m) begin M1_WVALID = v; M1_WLAST = last; end
    else   begin M0_WVALID = v; M0_WLAST = last; end
  endtask

  task automatic set_bready(input logic m, input logic v);
    if (m) M1_BREADY = v;
    else   M0_BREADY = v;
  endtask

  // Completes a transaction already in ADDR with an always-ready slave.
  task automatic finish_txn(input logic m, input int beats);
    logic [11:0] exp;
    S_AWREADY = 1;
    tick();
    S_WREADY = 1;
    for (int i = 0; i < beats; i++) begin
      set_w(m, 1'b1, (i == beats - 1));
      tick();
    end
    set_w(m, 1'b0, 1'b0);
    S_BVALID = 1;
    set_bready(m, 1'b1);
    exp = {1'b1, m, (m ? 3'b000 : 3'b001), (m ? 3'b001 : 3'b000), 4'b0001};
    #1 check_eq("txn_resp", obs, exp);
    tick();
    S_BVALID = 0; S_AWREADY = 0; S_WREADY = 0;
    set_bready(m, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Both request after reset: M0 first, 4-beat burst, then M1.
    do_reset("rst1");
    M0_AWVALID = 1; M1_AWVALID = 1;
    #1 check_eq("s1_idle_req", obs, 12'b0_0_000_000_0000);
    tick();
    check_eq("s1_addr", obs, 12'b1_0_000_000_1000);
    S_AWREADY = 1;
    #1 check_eq("s1_awhs", obs, 12'b1_0_100_000_1000);
    tick();
    M0_AWVALID = 0; M0_WVALID = 1; M0_WLAST = 0; S_WREADY = 1;
    #1 check_eq("s1_beat1", obs, 12'b1_0_010_000_0100);
    tick(); tick(); tick();
    M0_WLAST = 1;
    #1 check_eq("s1_last", obs, 12'b1_0_010_000_0110);
    tick();
    M0_WVALID = 0; M0_WLAST = 0; M0_BREADY = 1;
    #1 check_eq("s1_resp", obs, 12'b1_0_000_000_0001);
    S_BVALID = 1;
    #1 check_eq("s1_bvalid", obs, 12'b1_0_001_000_0001);
    tick();
    S_BVALID = 0; M0_BREADY = 0; M0_AWVALID = 1;
    #1 check_eq("s1_dwell", obs, 12'b0_0_000_000_0000);
    tick();
    check_eq("s1_regrant", obs, 12'b1_1_000_100_1000);
    finish_txn(1'b1, 1);

    // Lone M1, single beat, slave always ready: five-cycle walk.
    do_reset("rst2");
    M1_AWVALID = 1; M1_WVALID = 1; M1_WLAST = 1; M1_BREADY = 1;
    S_AWREADY = 1; S_WREADY = 1; S_BVALID = 1;
    #1 check_eq("s2_idle", obs, 12'b0_0_000_000_0000);
    tick();
    check_eq("s2_addr", obs, 12'b1_1_000_100_1000);
    tick();
    check_eq("s2_data", obs, 12'b1_1_000_010_0110);
    tick();
    check_eq("s2_resp", obs, 12'b1_1_000_001_0001);
    tick();
    check_eq("s2_idle_end", obs, 12'b0_1_000_000_0000);
    clear_inputs();

    // Early W data held off until AW handshake; AWVALID drop does not abort; BREADY stall.
    do_reset("rst3");
    M1_AWVALID = 1; M1_WVALID = 1; S_WREADY = 1;
    tick();
    check_eq("s3_stall1", obs, 12'b1_1_000_000_1000);
    tick();
    M1_AWVALID = 0;
    #1 check_eq("s3_awdrop", obs, 12'b1_1_000_000_0000);
    tick();
    M1_AWVALID = 1;
    #1 check_eq("s3_stall3", obs, 12'b1_1_000_000_1000);
    S_AWREADY = 1;
    #1 check_eq("s3_awhs", obs, 12'b1_1_000_100_1000);
    tick();
    M1_AWVALID = 0;
    #1 check_eq("s3_data", obs, 12'b1_1_000_010_0100);
    M1_WLAST = 1;
    tick();
    M1_WVALID = 0; M1_WLAST = 0; S_BVALID = 1;
    #1 check_eq("s3_bhold0", obs, 12'b1_1_000_001_0000);
    tick();
    check_eq("s3_bhold1", obs, 12'b1_1_000_001_0000);
    tick();
    check_eq("s3_bhold2", obs, 12'b1_1_000_001_0000);
    M1_BREADY = 1;
    #1 check_eq("s3_bhs", obs, 12'b1_1_000_001_0001);
    tick();
    check_eq("s3_idle", obs, 12'b0_1_000_000_0000);
    clear_inputs();

    // Reset in the middle of a 4-beat burst from M1.
    do_reset("rst4");
    M1_AWVALID = 1; S_AWREADY = 1;
    tick();
    tick();
    M1_AWVALID = 0; M1_WVALID = 1; S_WREADY = 1;
    tick(); tick();
    check_eq("s4_mid", obs, 12'b1_1_000_010_0100);
    ARESET = 1;
    tick();
    ARESET = 0;
    check_eq("s4_abort", obs, 12'b0_0_000_000_0000);
    clear_inputs();

    // Continuous requests from both: grants alternate 0,1,0,1.
    do_reset("rst5");
    M0_AWVALID = 1; M1_AWVALID = 1;
    for (int k = 0; k < 4; k++) begin
      logic exp_sel;
      exp_sel = k[0];
      tick();
      check_eq("s5_grant", obs, {1'b1, exp_sel, 6'b000000, 4'b1000});
      finish_txn(exp_sel, 2);
      #1 check_eq("s5_dwell", obs, {1'b0, exp_sel, 10'b0});
    end
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
